// File: rtl/processor_core_fsm_if.sv
// Command handshake plus architectural-state view of the multi-cycle RV32I core.
// The bench or host drives run/command through master; the core drives everything else through slave.
interface processor_core_fsm_if #(
    parameter int XLEN     = 32,
    parameter int NUM_REGS = 32
);
    logic                           run;
    logic [31:0]                    command;
    logic                           done;
    logic                           illegal;
    logic [NUM_REGS-1:0][XLEN-1:0]  regValues;
    logic [XLEN-1:0]                pc;
    logic [31:0]                    instret;

    modport master (output run, command, input done, illegal, regValues, pc, instret);
    modport slave  (input run, command, output done, illegal, regValues, pc, instret);
endinterface

// File: rtl/processor_core_fsm.sv
// Multi-cycle RV32I/RV32E core (OP, OP_IMM, LUI, AUIPC, JAL, JALR, BRANCH), no memory.
// One instruction per run/done handshake; accept edge E0, retire with done at E3; run/command ignored outside IDLE.
module processor_core_fsm #(
    parameter int              XLEN     = 32,
    parameter int              NUM_REGS = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic                 clk,
    input  logic                 reset,
    processor_core_fsm_if.slave  bus
);
    localparam int RIW = $clog2(NUM_REGS);

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    typedef enum logic [1:0] {S_IDLE, S_DECODE, S_EXECUTE, S_WRITEBACK} state_t;

    state_t                         r_state;
    logic [31:0]                    r_ir;
    logic [NUM_REGS-1:0][XLEN-1:0]  r_regs;
    logic [XLEN-1:0]                r_pc;
    logic [31:0]                    r_instret;
    logic                           r_done_pulse;
    logic                           r_illegal_flag;
    logic [XLEN-1:0]                r_rs1_val;
    logic [XLEN-1:0]                r_rs2_val;
    logic [XLEN-1:0]                r_imm;
    logic                           r_dec_ill;
    logic [XLEN-1:0]                r_result;
    logic [XLEN-1:0]                r_next_pc;
    logic                           r_wen;
    logic                           r_ex_ill;

    logic [6:0]      w_opcode;
    logic [2:0]      w_funct3;
    logic [6:0]      w_funct7;
    logic [4:0]      w_rd;
    logic [4:0]      w_rs1;
    logic [4:0]      w_rs2;
    logic [XLEN-1:0] w_imm_i;
    logic [XLEN-1:0] w_imm_b;
    logic [XLEN-1:0] w_imm_u;
    logic [XLEN-1:0] w_imm_j;

    assign w_opcode = r_ir[6:0];
    assign w_rd     = r_ir[11:7];
    assign w_funct3 = r_ir[14:12];
    assign w_rs1    = r_ir[19:15];
    assign w_rs2    = r_ir[24:20];
    assign w_funct7 = r_ir[31:25];
    assign w_imm_i  = {{(XLEN-12){r_ir[31]}}, r_ir[31:20]};
    assign w_imm_b  = {{(XLEN-13){r_ir[31]}}, r_ir[31], r_ir[7], r_ir[30:25], r_ir[11:8], 1'b0};
    assign w_imm_u  = {{(XLEN-32){r_ir[31]}}, r_ir[31:12], 12'b0};
    assign w_imm_j  = {{(XLEN-21){r_ir[31]}}, r_ir[31], r_ir[19:12], r_ir[20], r_ir[30:21], 1'b0};

    function automatic logic idx_bad(input logic [4:0] idx);
        return int'(idx) >= NUM_REGS;
    endfunction

    // Decode: pick the immediate, flag bad funct fields and out-of-range register indices
    logic            w_uses_rd, w_uses_rs1, w_uses_rs2, w_fn_ill, w_dec_ill;
    logic [XLEN-1:0] w_imm;
    always_comb begin
        w_uses_rd  = 1'b0;
        w_uses_rs1 = 1'b0;
        w_uses_rs2 = 1'b0;
        w_fn_ill   = 1'b0;
        w_imm      = w_imm_i;
        case (w_opcode)
            OPC_OP: begin
                w_uses_rd  = 1'b1;
                w_uses_rs1 = 1'b1;
                w_uses_rs2 = 1'b1;
                if (w_funct7 == 7'b0100000)
                    w_fn_ill = !(w_funct3 == 3'b000 || w_funct3 == 3'b101);
                else
                    w_fn_ill = (w_funct7 != 7'b0000000);
            end
            OPC_OP_IMM: begin
                w_uses_rd  = 1'b1;
                w_uses_rs1 = 1'b1;
                if (w_funct3 == 3'b001)
                    w_fn_ill = (w_funct7 != 7'b0000000);
                else if (w_funct3 == 3'b101)
                    w_fn_ill = !(w_funct7 == 7'b0000000 || w_funct7 == 7'b0100000);
            end
            OPC_LUI, OPC_AUIPC: begin
                w_uses_rd = 1'b1;
                w_imm     = w_imm_u;
            end
            OPC_JAL: begin
                w_uses_rd = 1'b1;
                w_imm     = w_imm_j;
            end
            OPC_JALR: begin
                w_uses_rd  = 1'b1;
                w_uses_rs1 = 1'b1;
                w_fn_ill   = (w_funct3 != 3'b000);
            end
            OPC_BRANCH: begin
                w_uses_rs1 = 1'b1;
                w_uses_rs2 = 1'b1;
                w_imm      = w_imm_b;
                w_fn_ill   = (w_funct3 == 3'b010 || w_funct3 == 3'b011);
            end
            default: w_fn_ill = 1'b1;
        endcase
        w_dec_ill = w_fn_ill | (w_uses_rd & idx_bad(w_rd)) |
                    (w_uses_rs1 & idx_bad(w_rs1)) | (w_uses_rs2 & idx_bad(w_rs2));
    end

    // Execute: ALU, branch compare and next-PC from the registered operands
    logic [XLEN-1:0] w_op_b, w_alu, w_result, w_target, w_next_pc, w_pc_plus4, w_jalr_sum;
    logic [4:0]      w_shamt;
    logic            w_taken, w_jump, w_wen, w_ex_ill;
    always_comb begin
        w_op_b     = (w_opcode == OPC_OP) ? r_rs2_val : r_imm;
        w_shamt    = w_op_b[4:0];
        w_pc_plus4 = r_pc + XLEN'(4);
        w_jalr_sum = r_rs1_val + r_imm;
        case (w_funct3)
            3'b000:  w_alu = (w_opcode == OPC_OP && w_funct7[5]) ? r_rs1_val - w_op_b : r_rs1_val + w_op_b;
            3'b001:  w_alu = r_rs1_val << w_shamt;
            3'b010:  w_alu = XLEN'($signed(r_rs1_val) < $signed(w_op_b));
            3'b011:  w_alu = XLEN'(r_rs1_val < w_op_b);
            3'b100:  w_alu = r_rs1_val ^ w_op_b;
            3'b101:  w_alu = w_funct7[5] ? XLEN'($signed(r_rs1_val) >>> w_shamt) : r_rs1_val >> w_shamt;
            3'b110:  w_alu = r_rs1_val | w_op_b;
            default: w_alu = r_rs1_val & w_op_b;
        endcase
        case (w_funct3)
            3'b000:  w_taken = (r_rs1_val == r_rs2_val);
            3'b001:  w_taken = (r_rs1_val != r_rs2_val);
            3'b100:  w_taken = ($signed(r_rs1_val) < $signed(r_rs2_val));
            3'b101:  w_taken = ($signed(r_rs1_val) >= $signed(r_rs2_val));
            3'b110:  w_taken = (r_rs1_val < r_rs2_val);
            default: w_taken = (r_rs1_val >= r_rs2_val);
        endcase
        w_result = w_alu;
        w_target = w_pc_plus4;
        w_jump   = 1'b0;
        w_wen    = 1'b0;
        case (w_opcode)
            OPC_OP, OPC_OP_IMM: w_wen = 1'b1;
            OPC_LUI: begin
                w_wen    = 1'b1;
                w_result = r_imm;
            end
            OPC_AUIPC: begin
                w_wen    = 1'b1;
                w_result = r_pc + r_imm;
            end
            OPC_JAL: begin
                w_wen    = 1'b1;
                w_jump   = 1'b1;
                w_result = w_pc_plus4;
                w_target = r_pc + r_imm;
            end
            OPC_JALR: begin
                w_wen    = 1'b1;
                w_jump   = 1'b1;
                w_result = w_pc_plus4;
                w_target = {w_jalr_sum[XLEN-1:1], 1'b0};
            end
            OPC_BRANCH: begin
                w_jump   = w_taken;
                w_target = r_pc + r_imm;
            end
            default: ;
        endcase
        w_ex_ill  = r_dec_ill | (w_jump & w_target[1]);
        w_next_pc = (w_jump && !w_ex_ill) ? w_target : w_pc_plus4;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state        <= S_IDLE;
            r_ir           <= '0;
            r_regs         <= '0;
            r_pc           <= RESET_PC;
            r_instret      <= '0;
            r_done_pulse   <= 1'b0;
            r_illegal_flag <= 1'b0;
            r_rs1_val      <= '0;
            r_rs2_val      <= '0;
            r_imm          <= '0;
            r_dec_ill      <= 1'b0;
            r_result       <= '0;
            r_next_pc      <= '0;
            r_wen          <= 1'b0;
            r_ex_ill       <= 1'b0;
        end else begin
            r_done_pulse   <= 1'b0;
            r_illegal_flag <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.run) begin
                        r_ir    <= bus.command;
                        r_state <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    r_rs1_val <= r_regs[r_ir[15 +: RIW]];
                    r_rs2_val <= r_regs[r_ir[20 +: RIW]];
                    r_imm     <= w_imm;
                    r_dec_ill <= w_dec_ill;
                    r_state   <= S_EXECUTE;
                end
                S_EXECUTE: begin
                    r_result  <= w_result;
                    r_next_pc <= w_next_pc;
                    r_wen     <= w_wen;
                    r_ex_ill  <= w_ex_ill;
                    r_state   <= S_WRITEBACK;
                end
                S_WRITEBACK: begin
                    // x0 is never written, so entry 0 keeps its reset value of zero
                    if (!r_ex_ill) begin
                        if (r_wen && w_rd != 5'd0)
                            r_regs[r_ir[7 +: RIW]] <= r_result;
                        r_instret <= r_instret + 32'd1;
                    end
                    r_pc           <= r_next_pc;
                    r_done_pulse   <= 1'b1;
                    r_illegal_flag <= r_ex_ill;
                    r_state        <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.done      = r_done_pulse;
    assign bus.illegal   = r_illegal_flag;
    assign bus.regValues = r_regs;
    assign bus.pc        = r_pc;
    assign bus.instret   = r_instret;
endmodule

// File: tb/tb_processor_core_fsm.sv
// Directed bench for processor_core_fsm: an RV32I instance and an RV32E (16-register) instance.
module tb_processor_core_fsm;
    logic clk = 1'b0;
    logic reset;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    processor_core_fsm_if #(.XLEN(32), .NUM_REGS(32)) ifa ();
    processor_core_fsm_if #(.XLEN(32), .NUM_REGS(16)) ifb ();

    processor_core_fsm #(.XLEN(32), .NUM_REGS(32), .RESET_PC(32'h0)) dut_a (
        .clk(clk), .reset(reset), .bus(ifa));
    processor_core_fsm #(.XLEN(32), .NUM_REGS(16), .RESET_PC(32'h0)) dut_b (
        .clk(clk), .reset(reset), .bus(ifb));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] enc_i(input int imm, input int rs1, input int f3, input int rd, input logic [6:0] op);
        logic [31:0] v;
        v = imm;
        return {v[11:0], 5'(rs1), 3'(f3), 5'(rd), op};
    endfunction

    function automatic logic [31:0] enc_r(input int f7, input int rs2, input int rs1, input int f3, input int rd);
        return {7'(f7), 5'(rs2), 5'(rs1), 3'(f3), 5'(rd), 7'h33};
    endfunction

    function automatic logic [31:0] enc_b(input int imm, input int rs2, input int rs1, input int f3);
        logic [31:0] v;
        v = imm;
        return {v[12], v[10:5], 5'(rs2), 5'(rs1), 3'(f3), v[4:1], v[11], 7'h63};
    endfunction

    function automatic logic [31:0] enc_j(input int imm, input int rd);
        logic [31:0] v;
        v = imm;
        return {v[20], v[10:1], v[11], v[19:12], 5'(rd), 7'h6F};
    endfunction

    function automatic logic [31:0] enc_u(input int imm20, input int rd, input logic [6:0] op);
        logic [31:0] v;
        v = imm20;
        return {v[19:0], 5'(rd), op};
    endfunction

    // Called at a negedge; returns at the negedge of the done cycle so a back-to-back call hits E4.
    task automatic exec(input bit sel, input logic [31:0] ins, input logic exp_ill, input string tag);
        int   n;
        logic d;
        logic il;
        if (sel) begin ifb.run = 1'b1; ifb.command = ins; end
        else     begin ifa.run = 1'b1; ifa.command = ins; end
        @(posedge clk);
        #1;
        ifa.run = 1'b0;
        ifb.run = 1'b0;
        ifa.command = $urandom;
        ifb.command = $urandom;
        n = 0;
        d = 1'b0;
        while (!d && n < 20) begin
            @(negedge clk);
            n++;
            d = sel ? ifb.done : ifa.done;
        end
        il = sel ? ifb.illegal : ifa.illegal;
        check({tag, ".latency"}, 32'(n), 32'd4);
        check({tag, ".illegal"}, {31'b0, il}, {31'b0, exp_ill});
    endtask

    initial begin
        int ndone;
        reset = 1'b1;
        ifa.run = 1'b0; ifa.command = '0;
        ifb.run = 1'b0; ifb.command = '0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("rst.pc", ifa.pc, 32'h0);
        check("rst.instret", ifa.instret, 32'h0);
        check("rst.done", {31'b0, ifa.done}, 32'h0);
        check("rst.illegal", {31'b0, ifa.illegal}, 32'h0);

        exec(0, enc_i(10, 0, 0, 1, 7'h13), 1'b0, "addi_x1");
        exec(0, enc_i(-4, 0, 0, 2, 7'h13), 1'b0, "addi_x2");
        check("x1", ifa.regValues[1], 32'd10);
        check("x2", ifa.regValues[2], 32'hFFFF_FFFC);
        check("pc.after2", ifa.pc, 32'h8);
        check("instret.after2", ifa.instret, 32'd2);
        @(negedge clk);
        check("done.cleared", {31'b0, ifa.done}, 32'h0);

        exec(0, enc_i(6, 0, 0, 3, 7'h13), 1'b0, "addi_x3");
        exec(0, enc_i(2, 0, 0, 7, 7'h13), 1'b0, "addi_x7");
        exec(0, enc_r(32, 2, 1, 0, 4), 1'b0, "sub");
        exec(0, enc_r(0, 2, 0, 3, 6), 1'b0, "sltu");
        exec(0, enc_r(0, 7, 2, 1, 10), 1'b0, "sll");
        exec(0, enc_r(0, 7, 2, 5, 11), 1'b0, "srl");
        exec(0, enc_r(32, 7, 2, 5, 12), 1'b0, "sra");
        check("x4.sub", ifa.regValues[4], 32'd14);
        check("x6.sltu", ifa.regValues[6], 32'd1);
        check("x10.sll", ifa.regValues[10], 32'hFFFF_FFF0);
        check("x11.srl", ifa.regValues[11], 32'h3FFF_FFFF);
        check("x12.sra", ifa.regValues[12], 32'hFFFF_FFFF);
        check("pc.alu", ifa.pc, 32'h24);

        exec(0, enc_i(32'h20, 0, 0, 0, 7'h67), 1'b0, "jalr_to20a");
        check("pc.jalr20", ifa.pc, 32'h20);
        exec(0, enc_b(8, 1, 1, 0), 1'b0, "beq");
        check("pc.beq", ifa.pc, 32'h28);
        exec(0, enc_i(32'h20, 0, 0, 0, 7'h67), 1'b0, "jalr_to20b");
        exec(0, enc_b(8, 1, 1, 1), 1'b0, "bne");
        check("pc.bne", ifa.pc, 32'h24);
        exec(0, enc_i(32'h20, 0, 0, 0, 7'h67), 1'b0, "jalr_to20c");
        exec(0, enc_b(-16, 1, 2, 4), 1'b0, "blt");
        check("pc.blt", ifa.pc, 32'h10);
        exec(0, enc_j(16, 5), 1'b0, "jal");
        check("x5.jal", ifa.regValues[5], 32'h14);
        check("pc.jal", ifa.pc, 32'h20);
        check("instret.jal", ifa.instret, 32'd16);

        exec(0, enc_i(32'h102, 0, 0, 6, 7'h67), 1'b1, "jalr_mis");
        check("x6.unchanged", ifa.regValues[6], 32'd1);
        check("pc.jalr_mis", ifa.pc, 32'h24);
        check("instret.jalr_mis", ifa.instret, 32'd16);

        exec(0, enc_i(5, 0, 0, 0, 7'h13), 1'b0, "addi_x0");
        check("x0", ifa.regValues[0], 32'h0);
        check("instret.x0", ifa.instret, 32'd17);
        exec(0, 32'h0000_007F, 1'b1, "opc7f");
        exec(0, enc_i(32'h021, 1, 1, 1, 7'h13), 1'b1, "slli_badf7");
        exec(0, enc_b(2, 0, 0, 0), 1'b1, "beq_mis");
        check("x1.kept", ifa.regValues[1], 32'd10);
        check("pc.illegals", ifa.pc, 32'h34);
        check("instret.illegals", ifa.instret, 32'd17);

        exec(0, enc_u(32'h12345, 8, 7'h37), 1'b0, "lui");
        exec(0, enc_u(1, 9, 7'h17), 1'b0, "auipc");
        exec(0, enc_i(32'h401, 2, 5, 14, 7'h13), 1'b0, "srai");
        check("x8.lui", ifa.regValues[8], 32'h1234_5000);
        check("x9.auipc", ifa.regValues[9], 32'h0000_1038);
        check("x14.srai", ifa.regValues[14], 32'hFFFF_FFFE);
        check("pc.final", ifa.pc, 32'h40);
        check("instret.final", ifa.instret, 32'd20);

        // Reset lands on the edge ending the EXECUTE cycle of an in-flight ADDI
        ifa.run = 1'b1;
        ifa.command = enc_i(10, 0, 0, 1, 7'h13);
        @(posedge clk);
        #1 ifa.run = 1'b0;
        @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        ndone = 0;
        repeat (6) begin
            @(negedge clk);
            if (ifa.done) ndone++;
        end
        check("rstmid.no_done", 32'(ndone), 32'd0);
        check("rstmid.x1", ifa.regValues[1], 32'h0);
        check("rstmid.x2", ifa.regValues[2], 32'h0);
        check("rstmid.pc", ifa.pc, 32'h0);
        check("rstmid.instret", ifa.instret, 32'h0);
        exec(0, enc_i(10, 0, 0, 1, 7'h13), 1'b0, "post_rst");
        check("post_rst.x1", ifa.regValues[1], 32'd10);
        check("post_rst.pc", ifa.pc, 32'h4);

        exec(1, enc_i(1, 0, 0, 20, 7'h13), 1'b1, "rv32e_x20");
        check("rv32e.pc", ifb.pc, 32'h4);
        check("rv32e.instret", ifb.instret, 32'd0);
        exec(1, enc_i(1, 0, 0, 15, 7'h13), 1'b0, "rv32e_x15");
        check("rv32e.x15", ifb.regValues[15], 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/processor_core_fsm.md
# processor_core_fsm

Multi-cycle RV32I execution core without memory, and the parametrised successor to `processor_no_mem`. The core accepts one externally supplied instruction per `run`/`done` handshake and maintains its own program counter. It executes OP, OP_IMM, LUI, AUIPC, JAL, JALR and BRANCH. Architectural state (register file, PC, retired-instruction count) is exposed on ports so a directed bench can check it directly. It sits between the command-sequencing bench or host and a future memory-attached fetch stage.

## Interface
- `XLEN`, 32: datapath and register width. Only 32 is supported in this generation.
- `NUM_REGS`, 32: architectural register count. Legal values are 32 (RV32I) and 16 (RV32E).
- `RESET_PC`, 0: PC value after reset.
- `clk`, input, 1: clock. All state updates on the rising edge.
- `reset`, input, 1: synchronous, active-high reset.
- `run`, input, 1: request to accept `command`. Sampled only in IDLE.
- `command`, input, 32: RV32 instruction word. Captured on the accepting edge.
- `done`, output, 1: one-cycle pulse marking instruction retirement or rejection.
- `illegal`, output, 1: valid only with `done`. High when the instruction was rejected.
- `regValues`, output, `NUM_REGS`×`XLEN`: register file contents. Entry 0 is always 0.
- `pc`, output, `XLEN`: current program counter.
- `instret`, output, 32: count of retired legal instructions. Wraps modulo 2^32.

## Operation
- FSM states: IDLE, DECODE, EXECUTE, WRITEBACK.
  - IDLE → DECODE on `run`=1: `command` is latched into the instruction register.
  - DECODE → EXECUTE unconditionally: fields and sign-extended immediates (I/S/B/U/J) are decoded, rs1/rs2 are read, and the illegal check runs.
  - EXECUTE → WRITEBACK unconditionally: ALU result, branch compare and next PC are registered.
  - WRITEBACK → IDLE unconditionally: rd is written, `pc` updated, `instret` incremented, `done`=1 for one cycle.
- ALU operations: ADD, SUB (funct7=0100000), SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND, plus the immediate forms.
  - Shift amount is operand bits [4:0].
  - SLLI/SRLI/SRAI with a non-zero funct7, other than SRAI's 0100000, is illegal.
- LUI writes imm_U<<12. AUIPC writes `pc`+(imm_U<<12).
- JAL/JALR:
  - rd ← `pc`+4.
  - Target is `pc`+sext(imm_J), or (rs1+sext(imm_I)) with bit 0 cleared for JALR.
- BRANCH (BEQ/BNE/BLT/BGE/BLTU/BGEU):
  - Taken: `pc` ← `pc`+sext(imm_B).
  - Not taken: `pc` ← `pc`+4.
- Default next PC is `pc`+4. All additions are modulo 2^32.
- Writes to x0 are discarded, so `regValues[0]` is always 0.
- Illegal instruction conditions:
  - unsupported opcode;
  - unsupported funct3/funct7 combination;
  - any rs1/rs2/rd index ≥ `NUM_REGS`;
  - a taken branch or jump whose target has bit 1 set (misaligned).
- Illegal instruction behaviour:
  - no register write;
  - `pc` ← `pc`+4;
  - `instret` unchanged;
  - `done`=1 and `illegal`=1 together.
- Reads in DECODE see all writes completed in earlier WRITEBACKs. There is no forwarding, because only one instruction is in flight.

## Timing
- Reset values:
  - all registers 0;
  - `pc`=`RESET_PC`;
  - `instret`=0;
  - `done`=0, `illegal`=0;
  - state IDLE.
- Reset asserted in any state discards the in-flight instruction. No write occurs and no `done` pulse is produced.
- Latency, with accept edge E0:
  - DECODE during E0–E1;
  - EXECUTE during E1–E2;
  - WRITEBACK during E2–E3;
  - at E3, `regValues`, `pc` and `instret` update and `done`=1 for the cycle E3–E4.
- `run` held high: the next instruction is accepted at E4, in the IDLE cycle where `done` is high. Throughput is one instruction per 4 cycles.
- `run` and `command` are ignored outside IDLE, and `command` may change freely after E0.
- `done`/`illegal` are registered outputs and are cleared at the next edge.

## Test plan
- ADDI x1,x0,10 then ADDI x2,x0,-4:
  - `done` at E3 of each;
  - x1=10, x2=0xFFFFFFFC;
  - `pc`=8, `instret`=2.
- With x1=10, x2=-4, x3=6, x7=2 preloaded by instructions:
  - SUB x4,x1,x2 → 14;
  - SLTU x6,x0,x2 → 1;
  - SLL x10,x2,x7 → -16;
  - SRL x11,x2,x7 → 0x3FFFFFFF;
  - SRA x12,x2,x7 → -1.
- Branches at `pc`=0x20:
  - BEQ x1,x1,+8 → `pc`=0x28;
  - BNE x1,x1,+8 → `pc`=0x24;
  - BLT x2,x1,-16 → `pc`=0x10.
- Jumps:
  - JAL x5,+16 at `pc`=0x10 → x5=0x14, `pc`=0x20;
  - JALR x6,x0,0x102 → `illegal`=1, x6 unchanged, `pc`+=4, `instret` unchanged.
- Illegal and x0 cases:
  - ADDI x0,x0,5 → `regValues[0]`=0 and `instret` increments;
  - opcode 7'h7F → `illegal`=1;
  - with `NUM_REGS`=16, ADDI x20,x0,1 → `illegal`=1.
- Reset asserted for one cycle during EXECUTE of ADDI x1,x0,10:
  - no `done` pulse;
  - x1=0, `pc`=`RESET_PC`;
  - the next `run` is accepted normally.
